lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between the execute stage and a
// request/grant memory bus, with byte-lane alignment, load extension and a bus watchdog.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_re,
    input  logic        ex_we,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_wen,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_store;
    logic        r_misalign;
    logic [7:0]  r_wdog;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_busy;
    logic        w_timeout;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [31:0] w_store_data;
    logic [3:0]  w_store_strb;

    assign ex_ready  = (r_state == IDLE);
    assign w_accept  = ex_valid && ex_ready && (ex_re || ex_we);
    assign w_busy    = (r_state == REQ) || (r_state == WAIT);
    assign w_timeout = w_busy && (r_wdog == 8'hFF);
    assign misalign  = r_misalign;
    assign bus_err   = w_timeout;

    // Size comes from funct3[1:0] alone, so 011/110/111 all behave as word accesses.
    always_comb begin
        w_misaligned = 1'b0;
        case (ex_funct3[1:0])
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = ex_addr[0];
            default: w_misaligned = (ex_addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        w_store_strb = 4'b1111;
        w_store_data = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_store_strb = 4'b0001 << r_addr[1:0];
                w_store_data = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_store_strb = 4'b0011 << r_addr[1:0];
                w_store_data = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: ;
        endcase
    end

    // A watchdog expiry overrides both grant and read response in the same cycle.
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wstrb    = '0;
        mem_wdata    = '0;
        wb_valid     = 1'b0;
        wb_wen       = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_misaligned) w_next_state = REQ;
            end
            REQ: begin
                if (w_timeout) begin
                    w_next_state = IDLE;
                end else begin
                    mem_req   = 1'b1;
                    mem_wr    = r_store;
                    mem_addr  = {r_addr[31:2], 2'b00};
                    mem_wstrb = r_store ? w_store_strb : 4'b0000;
                    mem_wdata = r_store ? w_store_data : 32'd0;
                    if (mem_gnt) w_next_state = r_store ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (w_timeout)       w_next_state = IDLE;
                else if (mem_rvalid) w_next_state = RESP;
            end
            RESP: begin
                wb_valid     = 1'b1;
                wb_wen       = !r_store;
                wb_rd        = r_store ? 5'd0 : r_rd;
                wb_data      = r_store ? 32'd0 : r_rdata;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
            r_rd       <= '0;
            r_store    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_accept && w_misaligned;
            if (w_accept) begin
                r_addr   <= ex_addr;
                r_wdata  <= ex_wdata;
                r_funct3 <= ex_funct3;
                r_rd     <= ex_rd;
                r_store  <= ex_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                             r_rdata <= '0;
        else if (r_state == WAIT && mem_rvalid && !w_timeout) r_rdata <= w_load_data;
    end

    // The watchdog restarts on every entry into REQ or WAIT and counts while there.
    always_ff @(posedge clk) begin
        if (rst)
            r_wdog <= '0;
        else if ((w_next_state != r_state) && (w_next_state == REQ || w_next_state == WAIT))
            r_wdog <= '0;
        else if (w_busy)
            r_wdog <= r_wdog + 8'd1;
    end

endmodule
